// File: rtl/execute_stage_pipe.sv
// EX stage of the pipelined MIPS core: operand forwarding, ALU, branch target,
// multi-cycle signed multiply into HI/LO, and the registered EX/MEM boundary.
module execute_stage_pipe #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned REGW       = 5,
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic             alusrc,
  input  logic             regdst,
  input  logic [2:0]       alucontrol,
  input  logic             mul_start,
  input  logic [1:0]       fwd_a,
  input  logic [1:0]       fwd_b,
  input  logic [WIDTH-1:0] reg1,
  input  logic [WIDTH-1:0] reg2,
  input  logic [REGW-1:0]  rt,
  input  logic [REGW-1:0]  rd,
  input  logic [WIDTH-1:0] signimm,
  input  logic [WIDTH-1:0] pcplus4,
  input  logic [WIDTH-1:0] mem_fwd,
  input  logic [WIDTH-1:0] wb_fwd,
  output logic             busy,
  output logic             ex_valid,
  output logic [WIDTH-1:0] ex_aluresult,
  output logic [WIDTH-1:0] ex_writedata,
  output logic [REGW-1:0]  ex_writereg,
  output logic             ex_zero,
  output logic             ex_overflow,
  output logic [WIDTH-1:0] ex_pcbranch
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;
  localparam int unsigned CW = $clog2(MUL_CYCLES);
  localparam logic [CW-1:0] CNT_INIT = CW'(MUL_CYCLES - 1);

  logic [0:0]         state;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   mul_a, mul_b, hi, lo;
  logic [WIDTH-1:0]   srca, fwdb, srcb, sum, diff, result, pcbranch;
  logic [2*WIDTH-1:0] prod;
  logic               overflow;

  assign busy = (state == S_BUSY);

  always_comb begin
    case (fwd_a)
      2'b01:   srca = wb_fwd;
      2'b10:   srca = mem_fwd;
      default: srca = reg1;
    endcase
    case (fwd_b)
      2'b01:   fwdb = wb_fwd;
      2'b10:   fwdb = mem_fwd;
      default: fwdb = reg2;
    endcase
  end

  assign srcb     = alusrc ? signimm : fwdb;
  assign sum      = srca + srcb;
  assign diff     = srca - srcb;
  assign pcbranch = pcplus4 + {signimm[WIDTH-3:0], 2'b00};
  // Operands are sign-extended to full product width so the low 2*WIDTH bits are the signed product.
  assign prod     = {{WIDTH{mul_a[WIDTH-1]}}, mul_a} * {{WIDTH{mul_b[WIDTH-1]}}, mul_b};

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (alucontrol)
      3'b010: begin
        result   = sum;
        overflow = (srca[WIDTH-1] == srcb[WIDTH-1]) && (sum[WIDTH-1] != srca[WIDTH-1]);
      end
      3'b110: begin
        result   = diff;
        overflow = (srca[WIDTH-1] != srcb[WIDTH-1]) && (diff[WIDTH-1] != srca[WIDTH-1]);
      end
      3'b000:  result = srca & srcb;
      3'b001:  result = srca | srcb;
      3'b111:  result = {{(WIDTH-1){1'b0}}, ($signed(srca) < $signed(srcb))};
      3'b011:  result = hi;
      3'b100:  result = lo;
      default: result = srcb;
    endcase
  end

  // Multiply FSM keeps counting through stall and flush; only reset aborts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      count <= '0;
      mul_a <= '0;
      mul_b <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (id_valid && mul_start && !flush && !stall) begin
            state <= S_BUSY;
            count <= CNT_INIT;
            mul_a <= srca;
            mul_b <= fwdb;
          end
        end
        default: begin
          if (count == '0) begin
            {hi, lo} <= prod;
            state    <= S_IDLE;
          end else begin
            count <= count - 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_aluresult <= '0;
      ex_writedata <= '0;
      ex_writereg  <= '0;
      ex_zero      <= 1'b0;
      ex_overflow  <= 1'b0;
      ex_pcbranch  <= '0;
    end else if (!stall) begin
      ex_valid     <= id_valid && !mul_start && !busy && !flush;
      ex_aluresult <= result;
      ex_writedata <= fwdb;
      ex_writereg  <= regdst ? rd : rt;
      ex_zero      <= (result == '0);
      ex_overflow  <= overflow;
      ex_pcbranch  <= pcbranch;
    end
  end

endmodule

// File: tb/tb_execute_stage_pipe.sv
// Scoreboard bench for execute_stage_pipe: directed cases then randomized traffic
// against a behavioural model of the EX stage, HI/LO and multiply latency.
module tb_execute_stage_pipe;
  localparam int unsigned W  = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned MC = 4;

  logic          clk = 1'b0;
  logic          reset, stall, flush, id_valid, alusrc, regdst, mul_start;
  logic [2:0]    alucontrol;
  logic [1:0]    fwd_a, fwd_b;
  logic [W-1:0]  reg1, reg2, signimm, pcplus4, mem_fwd, wb_fwd;
  logic [RW-1:0] rt, rd;
  logic          busy, ex_valid, ex_zero, ex_overflow;
  logic [W-1:0]  ex_aluresult, ex_writedata, ex_pcbranch;
  logic [RW-1:0] ex_writereg;

  always #5 clk = ~clk;

  execute_stage_pipe #(.WIDTH(W), .REGW(RW), .MUL_CYCLES(MC)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .alusrc(alusrc), .regdst(regdst), .alucontrol(alucontrol), .mul_start(mul_start),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .reg1(reg1), .reg2(reg2), .rt(rt), .rd(rd),
    .signimm(signimm), .pcplus4(pcplus4), .mem_fwd(mem_fwd), .wb_fwd(wb_fwd),
    .busy(busy), .ex_valid(ex_valid), .ex_aluresult(ex_aluresult),
    .ex_writedata(ex_writedata), .ex_writereg(ex_writereg), .ex_zero(ex_zero),
    .ex_overflow(ex_overflow), .ex_pcbranch(ex_pcbranch)
  );

  typedef struct {
    logic stall, flush, id_valid, alusrc, regdst, mul;
    logic [2:0] alu;
    logic [1:0] fa, fb;
    logic [31:0] reg1, reg2, imm, pc, memf, wbf;
    logic [4:0] rt, rd;
  } stim_t;
  typedef struct { logic [31:0] res, wdata, pcb; logic [4:0] wreg; logic zero, ovf; } out_t;
  typedef struct { logic busy, valid; } stat_t;

  out_t  out_q[$];
  stat_t stat_q[$];
  int    errors = 0;
  int    checks = 0;
  logic  mon_en = 1'b0;

  int          busy_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  longint      m_prod = 0;
  logic        m_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle_s();
    stim_t s;
    s = '{stall:0, flush:0, id_valid:0, alusrc:0, regdst:0, mul:0, alu:3'b010,
          fa:2'b00, fb:2'b00, reg1:0, reg2:0, imm:0, pc:0, memf:0, wbf:0, rt:0, rd:0};
    return s;
  endfunction

  function automatic stim_t op(input logic [2:0] alu, input logic [31:0] a, input logic [31:0] b);
    stim_t s;
    s = idle_s();
    s.id_valid = 1'b1; s.alu = alu; s.reg1 = a; s.reg2 = b;
    s.rt = 5'd3; s.rd = 5'd9; s.regdst = 1'b1; s.pc = 32'h0000_0040; s.imm = 32'h0000_0010;
    return s;
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] sel, input stim_t s, input logic [31:0] r);
    if (sel == 2'b01) return s.wbf;
    if (sel == 2'b10) return s.memf;
    return r;
  endfunction

  // Reference: what the EX/MEM boundary and the multiplier should do at the coming edge.
  task automatic model_step(input stim_t s);
    logic [31:0] a, fbv, b, res;
    longint r;
    logic ovf, busy_now;
    out_t o;
    stat_t st;
    a = pick(s.fa, s, s.reg1);
    fbv = pick(s.fb, s, s.reg2);
    b = s.alusrc ? s.imm : fbv;
    busy_now = (busy_left > 0);
    ovf = 1'b0;
    r = 0;
    case (s.alu)
      3'b010: begin r = longint'($signed(a)) + longint'($signed(b)); res = r[31:0];
                    ovf = (r != longint'($signed(res))); end
      3'b110: begin r = longint'($signed(a)) - longint'($signed(b)); res = r[31:0];
                    ovf = (r != longint'($signed(res))); end
      3'b000: res = a & b;
      3'b001: res = a | b;
      3'b111: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b011: res = m_hi;
      3'b100: res = m_lo;
      default: res = b;
    endcase
    if (!s.stall) begin
      m_valid = s.flush ? 1'b0 : (s.id_valid && !s.mul && !busy_now);
      if (m_valid) begin
        o.res = res; o.wdata = fbv; o.pcb = s.pc + s.imm * 4;
        o.wreg = s.regdst ? s.rd : s.rt; o.zero = (res == 0); o.ovf = ovf;
        out_q.push_back(o);
      end
    end
    if (busy_now) begin
      busy_left--;
      if (busy_left == 0) {m_hi, m_lo} = m_prod;
    end else if (s.id_valid && s.mul && !s.flush && !s.stall) begin
      busy_left = MC;
      m_prod = longint'($signed(a)) * longint'($signed(fbv));
    end
    st.busy = (busy_left > 0);
    st.valid = m_valid;
    stat_q.push_back(st);
  endtask

  task automatic apply(input stim_t s);
    stall = s.stall; flush = s.flush; id_valid = s.id_valid; alusrc = s.alusrc;
    regdst = s.regdst; mul_start = s.mul; alucontrol = s.alu; fwd_a = s.fa; fwd_b = s.fb;
    reg1 = s.reg1; reg2 = s.reg2; signimm = s.imm; pcplus4 = s.pc; mem_fwd = s.memf;
    wb_fwd = s.wbf; rt = s.rt; rd = s.rd;
  endtask

  task automatic run(input stim_t s);
    @(negedge clk);
    apply(s);
    model_step(s);
    mon_en = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    mon_en = 1'b0;
    apply(idle_s());
    #2 reset = 1'b1;
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_valid", {31'd0, ex_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    busy_left = 0; m_hi = '0; m_lo = '0; m_valid = 1'b0;
    out_q.delete();
    stat_q.delete();
  endtask

  // Monitor: status every edge, result fields whenever a fresh EX/MEM entry appears.
  initial begin
    stat_t es;
    out_t eo, last;
    logic st_s;
    last = '{res:0, wdata:0, pcb:0, wreg:0, zero:0, ovf:0};
    forever begin
      @(posedge clk);
      st_s = stall;
      #1;
      if (mon_en && !reset) begin
        es = '{busy:0, valid:0};
        if (stat_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL status_queue actual=empty required=entry at %0t", $time);
        end else begin
          es = stat_q.pop_front();
          chk("busy", {31'd0, busy}, {31'd0, es.busy});
          chk("ex_valid", {31'd0, ex_valid}, {31'd0, es.valid});
        end
        if (!st_s && ex_valid) begin
          if (out_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL out_queue actual=unexpected_valid required=none at %0t", $time);
          end else begin
            eo = out_q.pop_front();
            last = eo;
            chk("aluresult", ex_aluresult, eo.res);
            chk("writedata", ex_writedata, eo.wdata);
            chk("writereg", {27'd0, ex_writereg}, {27'd0, eo.wreg});
            chk("zero", {31'd0, ex_zero}, {31'd0, eo.zero});
            chk("overflow", {31'd0, ex_overflow}, {31'd0, eo.ovf});
            chk("pcbranch", ex_pcbranch, eo.pcb);
          end
        end else if (st_s && ex_valid && es.valid) begin
          chk("hold_aluresult", ex_aluresult, last.res);
          chk("hold_pcbranch", ex_pcbranch, last.pcb);
          chk("hold_writereg", {27'd0, ex_writereg}, {27'd0, last.wreg});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    reset = 1'b1;
    apply(idle_s());
    @(negedge clk);
    @(negedge clk);
    chk("rst_aluresult", ex_aluresult, 32'd0);
    chk("rst_pcbranch", ex_pcbranch, 32'd0);
    chk("rst_flags", {28'd0, busy, ex_valid, ex_zero, ex_overflow}, 32'd0);
    reset = 1'b0;

    run(op(3'b010, 32'h7FFF_FFFF, 32'h0000_0001));
    s = op(3'b010, 32'd9, 32'd0); s.fa = 2'b10; s.memf = 32'd5; s.alusrc = 1'b1; s.imm = 32'hFFFF_FFFD;
    run(s);
    run(op(3'b111, 32'hFFFF_FFFF, 32'd1));
    run(op(3'b110, 32'd7, 32'd7));
    run(op(3'b110, 32'h8000_0000, 32'd1));
    s = op(3'b001, 32'h0F0F_0000, 32'h0000_00F0); s.pc = 32'h100; s.imm = 32'd4; s.fb = 2'b01; s.wbf = 32'h55;
    run(s);

    s = op(3'b010, 32'hFFFF_FFFE, 32'd3); s.mul = 1'b1;
    run(s);
    for (int i = 0; i < int'(MC); i++) run(op(3'b010, 32'd1, 32'd2));
    run(op(3'b011, 32'd0, 32'd0));
    run(op(3'b100, 32'd0, 32'd0));

    run(op(3'b000, 32'hDEAD_BEEF, 32'h0FF0_FF00));
    for (int i = 0; i < 3; i++) begin
      s = op(3'b010, 32'd100 + i, 32'd1); s.stall = 1'b1; run(s);
    end
    s = op(3'b010, 32'd1, 32'd1); s.flush = 1'b1; run(s);
    run(op(3'b101, 32'd0, 32'h1234_5678));

    s = op(3'b010, 32'hFFFF_FFFB, 32'd7); s.mul = 1'b1;
    run(s);
    run(idle_s());
    do_reset();
    for (int i = 0; i < int'(MC) + 2; i++) run(idle_s());
    run(op(3'b011, 32'd0, 32'd0));
    run(op(3'b100, 32'd0, 32'd0));

    for (int n = 0; n < 400; n++) begin
      s = idle_s();
      s.stall = ($urandom_range(0, 6) == 0);
      s.flush = ($urandom_range(0, 8) == 0);
      s.id_valid = ($urandom_range(0, 4) != 0);
      s.mul = ($urandom_range(0, 7) == 0);
      s.alusrc = s.mul ? 1'b0 : 1'($urandom_range(0, 1));
      s.regdst = 1'($urandom_range(0, 1));
      s.alu = 3'($urandom_range(0, 7));
      s.fa = 2'($urandom_range(0, 3));
      s.fb = 2'($urandom_range(0, 3));
      s.reg1 = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF + $urandom_range(0, 2) : $urandom;
      s.reg2 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
      s.imm = ($urandom_range(0, 1) == 0) ? 32'($signed(16'($urandom))) : $urandom;
      s.pc = $urandom; s.memf = $urandom; s.wbf = $urandom;
      s.rt = 5'($urandom); s.rd = 5'($urandom);
      run(s);
    end
    for (int i = 0; i < int'(MC) + 2; i++) run(idle_s());
    @(posedge clk);
    #2;
    chk("drain_out_q", 32'(out_q.size()), 32'd0);
    chk("drain_stat_q", 32'(stat_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
